stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_seq_pkg.sv | 25 ++
 rtl/ack_watchdog.sv | 37 +++
 rtl/stage_sequencer.sv | 142 ++++++++++++++
 tb/tb_stage_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_pkg.sv
// Shared definitions for the instruction stage sequencer: state encodings,
// default parameter values and a small state classification helper.
package stage_seq_pkg;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_EXECUTE = 3'b011,
    ST_MEMORY  = 3'b100,
    ST_WRITE   = 3'b101,
    ST_ERROR   = 3'b110,
    ST_HALT    = 3'b111
  } state_t;

  // States that count as active execution time for the cycle counter.
  function automatic logic is_active(input state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXECUTE) ||
           (s == ST_MEMORY) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts cycles a memory request waits without acknowledge and flags a
// timeout on the last permitted cycle; an acknowledge on that cycle wins.
module ack_watchdog
  import stage_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_active,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT);
  assign timeout    = wait_active && !ack && w_at_limit;

  // Saturates at the limit; the sequencer leaves the wait state there anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (wait_active && !ack && !w_at_limit) begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH..WRITE with memory
// handshakes, single-step control, halt handling and performance counters.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             needs_mem,
  input  logic             reg_write_en,
  input  logic             halt_req,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_load,
  output logic [2:0]       state,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  logic w_wait_active;
  logic w_ack;
  logic w_clear;
  logic w_timeout;

  assign w_wait_active = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
  assign w_ack         = ((r_state == ST_FETCH)  && imem_ack) ||
                         ((r_state == ST_MEMORY) && dmem_ack);
  // Held clear outside the wait states, so every entry starts from zero.
  assign w_clear       = !w_wait_active;

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_clear),
    .wait_active(w_wait_active),
    .ack        (w_ack),
    .timeout    (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HALT;
    end else begin
      unique case (r_state)
        ST_HALT: begin
          if (run_en) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (run_en && (!step_mode || step_req)) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack)       r_state <= ST_DECODE;
          else if (w_timeout) r_state <= ST_ERROR;
        end
        ST_DECODE: begin
          r_state <= halt_req ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          r_state <= needs_mem ? ST_MEMORY : ST_WRITE;
        end
        ST_MEMORY: begin
          if (dmem_ack)       r_state <= ST_WRITE;
          else if (w_timeout) r_state <= ST_ERROR;
        end
        ST_WRITE: begin
          r_state <= (run_en && !step_mode) ? ST_FETCH : ST_IDLE;
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (is_active(r_state)) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if (r_state == ST_WRITE) r_instret_cnt <= r_instret_cnt + CNT_ONE;
    end
  end

  always_comb begin
    if_en       = 1'b0;
    id_en       = 1'b0;
    exe_en      = 1'b0;
    mem_en      = 1'b0;
    wb_en       = 1'b0;
    pc_load     = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    timeout_err = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if_en    = 1'b1;
        imem_req = 1'b1;
      end
      ST_DECODE:  id_en = 1'b1;
      ST_EXECUTE: exe_en = 1'b1;
      ST_MEMORY: begin
        mem_en   = 1'b1;
        dmem_req = 1'b1;
      end
      ST_WRITE: begin
        wb_en   = reg_write_en;
        pc_load = 1'b1;
      end
      ST_ERROR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == ST_HALT);
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: per-instruction plans drive a memory
// responder; expected retire/halt events come from per-instruction arithmetic.
module tb_stage_sequencer;
  import stage_seq_pkg::*;

  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned TB_TO    = 4;
  localparam int          CMOD     = 1 << TB_CNT_W;

  logic clk = 1'b0;
  logic rst, run_en, step_mode, step_req;
  logic imem_req, imem_ack, dmem_req, dmem_ack;
  logic needs_mem, reg_write_en, halt_req;
  logic if_en, id_en, exe_en, mem_en, wb_en, pc_load;
  logic [2:0] state;
  logic halted, timeout_err;
  logic [TB_CNT_W-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  stage_sequencer #(.CNT_W(TB_CNT_W), .ACK_TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step_mode(step_mode), .step_req(step_req),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .needs_mem(needs_mem), .reg_write_en(reg_write_en), .halt_req(halt_req),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .pc_load(pc_load), .state(state), .halted(halted), .timeout_err(timeout_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // fd/md: wait cycles before imem/dmem ack (fd >= TB_TO means never acked)
  typedef struct { int fd; int md; bit nm; bit rwe; bit halt; } plan_t;
  typedef struct { int kind; bit wb; int cyc; int ret; } exp_t;  // kind 0=retire 1=halt

  plan_t plan_q[$];
  exp_t  exp_q[$];
  plan_t cur;
  int m_cycles, m_instret, if_wait, md_wait;
  int tests, fails;
  bit prev_halted = 1'b1;

  function automatic void check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic plan_t mk_plan(input int fd, input int md, input bit nm, input bit rwe, input bit halt);
    plan_t p;
    p.fd = fd; p.md = md; p.nm = nm; p.rwe = rwe; p.halt = halt;
    return p;
  endfunction

  function automatic plan_t rand_plan(input bit halt_ok);
    return mk_plan(int'($urandom_range(0, TB_TO - 1)), int'($urandom_range(0, TB_TO - 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   halt_ok && ($urandom_range(0, 7) == 0));
  endfunction

  // Instruction cost: fetch waits+1, decode, execute, optional memory waits+1, write.
  function automatic void issue_expect(input plan_t p);
    exp_t e;
    int c;
    if (p.fd >= int'(TB_TO)) return;
    if (p.halt) begin
      c = p.fd + 2;
      e.kind = 1; e.wb = 1'b0; e.cyc = (m_cycles + c) % CMOD; e.ret = m_instret % CMOD;
      m_cycles += c;
    end else begin
      c = p.fd + 3 + (p.nm ? p.md + 1 : 0);
      e.kind = 0; e.wb = p.rwe; e.cyc = (m_cycles + c) % CMOD; e.ret = m_instret % CMOD;
      m_cycles += c + 1;
      m_instret++;
    end
    exp_q.push_back(e);
  endfunction

  // Memory responder: random acks while nothing is requested.
  always @(negedge clk) begin
    if (rst) begin
      imem_ack = 1'b0; dmem_ack = 1'b0; if_wait = 0; md_wait = 0;
    end else begin
      if (imem_req) begin
        if (if_wait == 0) begin
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front();
          end else begin
            tests++; fails++;
            $display("FAIL unplanned_fetch: got fetch expected none (t=%0t)", $time);
            cur = mk_plan(99, 0, 1'b0, 1'b0, 1'b0);
          end
          needs_mem = cur.nm; reg_write_en = cur.rwe; halt_req = cur.halt;
          issue_expect(cur);
        end
        imem_ack = (if_wait == cur.fd);
        if_wait++;
      end else begin
        if_wait = 0;
        imem_ack = 1'($urandom_range(0, 1));
      end
      if (dmem_req) begin
        dmem_ack = (md_wait == cur.md);
        md_wait++;
      end else begin
        md_wait = 0;
        dmem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard on every retire (pc_load) and halt entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("strobe_onehot", int'($countones({if_en, id_en, exe_en, mem_en}) <= 1), 1);
      if (pc_load) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_retire: got retire expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("retire_kind", 0, e.kind);
          check("retire_wb_en", wb_en, e.wb);
          check("retire_cycle_cnt", cycle_cnt, e.cyc);
          check("retire_instret", instret_cnt, e.ret);
        end
      end
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_halt: got halt expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("halt_kind", 1, e.kind);
          check("halt_cycle_cnt", cycle_cnt, e.cyc);
          check("halt_pc_load", pc_load, 0);
        end
      end
    end
    prev_halted = halted;
  end

  task automatic model_reset();
    plan_q.delete(); exp_q.delete();
    m_cycles = 0; m_instret = 0;
    run_en = 1'b0; step_mode = 1'b0; step_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
    int n = 0;
    while (state !== s && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, state, s);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (plan_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    run_en = 1'b0;
    check(name, plan_q.size(), 0);
  endtask

  task automatic count_fetch(output int nf);
    nf = 0;
    while (state == ST_FETCH && nf < 20) begin
      nf++;
      @(negedge clk);
    end
  endtask

  logic [2:0] seq [14];
  int nf;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; needs_mem = 1'b0; reg_write_en = 1'b0; halt_req = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_state", state, ST_HALT);
    check("rst_halted", halted, 1);
    check("rst_strobes", {if_en, id_en, exe_en, mem_en, wb_en, pc_load, imem_req, dmem_req}, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_instret", instret_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_hold", state, ST_HALT);

    // Plain ALU op, then a load with 3 wait cycles; run_en drops mid-load.
    plan_q.push_back(mk_plan(0, 0, 1'b0, 1'b1, 1'b0));
    plan_q.push_back(mk_plan(0, 3, 1'b1, 1'b1, 1'b0));
    seq = '{ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITE, ST_FETCH, ST_DECODE,
            ST_EXECUTE, ST_MEMORY, ST_MEMORY, ST_MEMORY, ST_MEMORY, ST_WRITE, ST_IDLE};
    run_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("seq%0d", i), state, seq[i]);
      if (i == 4) begin
        check("w1_wb_en", wb_en, 1);
        check("w1_pc_load", pc_load, 1);
      end
      if (i == 5) begin
        check("w1_instret", instret_cnt, 1);
        check("w1_cycle_cnt", cycle_cnt, 4);
        run_en = 1'b0;
      end
      if (seq[i] == ST_MEMORY) check("mem_dmem_req", dmem_req, 1);
    end
    check("load_cycle_cnt", cycle_cnt, 12);

    // Single-step: two pulses, two retires, back to IDLE each time.
    step_mode = 1'b1; run_en = 1'b1;
    plan_q.push_back(rand_plan(1'b0));
    plan_q.push_back(rand_plan(1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("step_idle_hold", state, ST_IDLE);
    end
    for (int k = 0; k < 2; k++) begin
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      check("step_fetch", state, ST_FETCH);
      wait_state(ST_IDLE, 40, "step_return_idle");
      check("step_instret", instret_cnt, 3 + k);
    end

    // Halt request in DECODE.
    step_mode = 1'b0;
    plan_q.push_back(mk_plan(1, 0, 1'b0, 1'b1, 1'b1));
    wait_state(ST_HALT, 20, "halt_reached");
    run_en = 1'b0;
    check("halt_halted", halted, 1);
    check("halt_no_pc_load", pc_load, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_sticky", state, ST_HALT);
    end

    // Random instruction mix, counters wrap freely.
    for (int i = 0; i < 40; i++) plan_q.push_back(rand_plan(1'b1));
    run_en = 1'b1;
    drain("rand_progress");
    repeat (20) @(negedge clk);
    check("rand_settled", int'(state == ST_IDLE || state == ST_HALT), 1);
    check("rand_sb_empty", exp_q.size(), 0);

    // Fetch timeout: never acked, ERROR is terminal.
    do_reset();
    plan_q.push_back(mk_plan(99, 0, 1'b0, 1'b0, 1'b0));
    run_en = 1'b1;
    wait_state(ST_FETCH, 5, "to_fetch_entry");
    count_fetch(nf);
    check("to_fetch_cycles", nf, 4);
    check("to_state", state, ST_ERROR);
    check("to_err_flag", timeout_err, 1);
    check("to_strobes", {if_en, id_en, exe_en, mem_en, wb_en, pc_load, imem_req, dmem_req}, 0);
    for (int i = 0; i < 6; i++) begin
      run_en = ~run_en;
      @(negedge clk);
      check("to_error_hold", state, ST_ERROR);
    end

    // Reset mid-request drops imem_req immediately.
    do_reset();
    plan_q.push_back(mk_plan(99, 0, 1'b0, 1'b0, 1'b0));
    run_en = 1'b1;
    wait_state(ST_FETCH, 5, "rr_fetch_entry");
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rr_imem_req_drop", imem_req, 0);
    check("rr_state", state, ST_HALT);
    check("rr_err_clear", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_post_halt", state, ST_HALT);

    // Ack exactly on the timeout boundary wins.
    plan_q.push_back(mk_plan(3, 0, 1'b0, 1'b1, 1'b0));
    run_en = 1'b1;
    wait_state(ST_FETCH, 5, "bd_fetch_entry");
    run_en = 1'b0;
    count_fetch(nf);
    check("bd_fetch_cycles", nf, 4);
    check("bd_state", state, ST_DECODE);
    check("bd_err_flag", timeout_err, 0);
    wait_state(ST_IDLE, 20, "bd_idle");

    // Sixteen retires wrap the 4-bit counters.
    do_reset();
    for (int i = 0; i < 16; i++) plan_q.push_back(mk_plan(0, 0, 1'b0, 1'b0, 1'b0));
    run_en = 1'b1;
    drain("wrap_progress");
    wait_state(ST_IDLE, 20, "wrap_idle");
    check("wrap_instret", instret_cnt, 0);
    check("wrap_cycle_cnt", cycle_cnt, 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
